// File: rtl/ufm_reader_if.sv
// ufm_reader_if: upstream request/response bundle for the UFM reader.
// master = fetch logic, slave = ufm_reader.
interface ufm_reader_if #(
  parameter int ADDR_W = 12
);
  logic              req;
  logic [ADDR_W-1:0] addr;
  logic              ready;
  logic [31:0]       data;
  logic              valid;
  logic              err;

  modport master (
    output req, addr,
    input  ready, data, valid, err
  );

  modport slave (
    input  req, addr,
    output ready, data, valid, err
  );
endinterface

// File: rtl/ufm_reader.sv
// ufm_reader: serial read controller for the MAX 10 UFM flash block.
// Optional macro UFM_READER_BURST_EN: sequential reads use address increment.
module ufm_reader #(
  parameter int CLK_DIV     = 8,
  parameter int ADDR_W      = 12,
  parameter int MAX_ADDR    = 3071,
  parameter int ARDIN_W     = 23,
  parameter int ADDR_OFFSET = 0
) (
  input  logic        CLK100MHZ,
  input  logic        reset_n,
  ufm_reader_if.slave bus,
  output logic        arclk,
  output logic        arshft,
  output logic        ardin,
  output logic        drclk,
  output logic        drshft,
  input  logic        drdout
);

  localparam int HALF = CLK_DIV / 2;
  localparam int PH_W = $clog2(CLK_DIV);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_INCR,
    S_LOAD,
    S_DATA,
    S_DONE
  } state_t;

  state_t             state;
  logic [PH_W-1:0]    phase;
  logic [7:0]         cnt;
  logic [ARDIN_W-1:0] a_q;
  logic [31:0]        sh;
  logic [ARDIN_W-1:0] a_next;
  logic               in_range;
  logic               seq;
  logic               ph_mid;
  logic               ph_last;

  assign a_next   = ARDIN_W'(bus.addr)
                  + ARDIN_W'(ADDR_OFFSET);
  assign in_range = 32'(bus.addr) <= 32'(MAX_ADDR);
  assign ph_mid   = phase == PH_W'(HALF - 1);
  assign ph_last  = phase == PH_W'(CLK_DIV - 1);

`ifdef UFM_READER_BURST_EN
  logic [ADDR_W-1:0] last_q;
  logic [ADDR_W-1:0] addr_q;
  logic              last_ok;

  assign seq = last_ok
             && (32'(last_q) < 32'(MAX_ADDR))
             && (bus.addr == last_q + 1'b1);

  // remember the address of the last completed read
  always_ff @(posedge CLK100MHZ or negedge reset_n) begin
    if (!reset_n) begin
      last_q  <= '0;
      addr_q  <= '0;
      last_ok <= 1'b0;
    end else begin
      if (state == S_IDLE && bus.req && in_range)
        addr_q <= bus.addr;
      if (state == S_DONE) begin
        last_q  <= addr_q;
        last_ok <= 1'b1;
      end
    end
  end
`else
  assign seq = 1'b0;
`endif

  // sequencer: flash clocks, serial address, data capture
  always_ff @(posedge CLK100MHZ or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      phase     <= '0;
      cnt       <= '0;
      a_q       <= '0;
      sh        <= '0;
      bus.ready <= 1'b1;
      bus.data  <= '0;
      bus.valid <= 1'b0;
      bus.err   <= 1'b0;
      arclk     <= 1'b0;
      drclk     <= 1'b0;
      arshft    <= 1'b1;
      drshft    <= 1'b1;
      ardin     <= 1'b0;
    end else begin
      bus.valid <= 1'b0;
      bus.err   <= 1'b0;
      unique case (state)
        S_IDLE: begin
          phase <= '0;
          cnt   <= '0;
          if (bus.req) begin
            if (in_range) begin
              bus.ready <= 1'b0;
              a_q       <= a_next << 1;
              if (seq) begin
                state  <= S_INCR;
                arshft <= 1'b0;
              end else begin
                state  <= S_ADDR;
                arshft <= 1'b1;
                ardin  <= a_next[ARDIN_W-1];
              end
            end else begin
              bus.err <= 1'b1;
            end
          end
        end
        S_DONE: begin
          bus.data  <= sh;
          bus.valid <= 1'b1;
          bus.ready <= 1'b1;
          state     <= S_IDLE;
        end
        default: begin
          phase <= ph_last ? '0 : phase + 1'b1;
          if (ph_mid) begin
            if (state == S_DATA) begin
              sh    <= {sh[30:0], drdout};
              // shift follows each sample but the last
              drclk <= (cnt != 8'd31);
            end else if (state == S_LOAD) begin
              drclk <= 1'b1;
            end else begin
              arclk <= 1'b1;
            end
          end
          if (ph_last) begin
            arclk <= 1'b0;
            drclk <= 1'b0;
            cnt   <= cnt + 1'b1;
            if (state == S_ADDR) begin
              if (cnt == 8'(ARDIN_W - 1)) begin
                state  <= S_LOAD;
                cnt    <= '0;
                drshft <= 1'b0;
                ardin  <= 1'b0;
              end else begin
                ardin <= a_q[ARDIN_W-1];
                a_q   <= a_q << 1;
              end
            end else if (state == S_INCR) begin
              state  <= S_LOAD;
              cnt    <= '0;
              arshft <= 1'b1;
              drshft <= 1'b0;
            end else if (state == S_LOAD) begin
              state  <= S_DATA;
              cnt    <= '0;
              drshft <= 1'b1;
            end else if (cnt == 8'd31) begin
              state <= S_DONE;
              cnt   <= '0;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ufm_reader.sv
// tb_ufm_reader: random reads against a behavioural flash block
// and a transaction-level model of latency, data and clock counts.
module tb_ufm_reader;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic arclk, arshft, ardin;
  logic drclk, drshft, drdout;

  int checks = 0;
  int errors = 0;

  ufm_reader_if #(.ADDR_W(12)) bus ();

  ufm_reader dut (
    .CLK100MHZ (clk),
    .reset_n   (reset_n),
    .bus       (bus),
    .arclk     (arclk),
    .arshft    (arshft),
    .ardin     (ardin),
    .drclk     (drclk),
    .drshft    (drshft),
    .drdout    (drdout)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:3071];
  logic [22:0] areg = '0;
  logic [31:0] dreg = '0;
  int ar_n = 0, inc_n = 0, ld_n = 0, sh_n = 0, v_n = 0;

  assign drdout = dreg[31];

  // flash address register
  always @(posedge arclk) begin
    ar_n <= ar_n + 1;
    if (arshft) areg <= {areg[21:0], ardin};
    else begin
      areg  <= areg + 23'd1;
      inc_n <= inc_n + 1;
    end
  end

  // flash data register
  always @(posedge drclk) begin
    if (!drshft) begin
      dreg <= (areg < 23'd3072) ? mem[areg[11:0]] : 32'd0;
      ld_n <= ld_n + 1;
    end else begin
      dreg <= dreg << 1;
      sh_n <= sh_n + 1;
    end
  end

  // valid pulse counter
  always @(posedge clk) if (bus.valid) v_n <= v_n + 1;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

`ifdef UFM_READER_BURST_EN
  bit burst_en = 1'b1;
`else
  bit burst_en = 1'b0;
`endif
  bit          m_ok = 1'b0;
  logic [11:0] m_last = '0;

  task automatic rd(input logic [11:0] a, input bit hold);
    int lat, ar0, inc0, ld0, sh0, v0, lexp;
    bit seen, ok, sq;
    ok = (a <= 12'd3071);
    sq = burst_en && m_ok && (m_last < 12'd3071)
      && (a == m_last + 12'd1);
    ar0 = ar_n; inc0 = inc_n; ld0 = ld_n; sh0 = sh_n; v0 = v_n;
    @(negedge clk);
    bus.req = 1'b1;
    bus.addr = a;
    @(posedge clk); #1;
    if (hold) bus.addr = 12'd0;
    else bus.req = 1'b0;
    if (!ok) begin
      bus.req = 1'b0;
      chk("err", 32'(bus.err), 1);
      chk("err_rdy", 32'(bus.ready), 1);
      @(posedge clk); #1;
      chk("err_pulse", 32'(bus.err), 0);
      repeat (20) @(posedge clk);
      #1;
      chk("err_clk", ar_n - ar0 + ld_n - ld0 + sh_n - sh0, 0);
      return;
    end
    chk("busy", 32'(bus.ready), 0);
    lat = 0;
    seen = 1'b0;
    while (!seen && lat < 1000) begin
      @(posedge clk); #1;
      lat++;
      seen = bus.valid;
    end
    bus.req = 1'b0;
    lexp = ((sq ? 1 : 23) + 1 + 32) * 8 + 1;
    chk("lat", lat, lexp);
    chk("data", bus.data, mem[a]);
    chk("ready", 32'(bus.ready), 1);
    chk("arclk", ar_n - ar0, sq ? 1 : 23);
    chk("incr", inc_n - inc0, sq ? 1 : 0);
    chk("load", ld_n - ld0, 1);
    chk("shift", sh_n - sh0, 31);
    chk("faddr", 32'(areg), 32'(a));
    repeat (4) @(posedge clk);
    #1;
    chk("vcnt", v_n - v0, 1);
    m_last = a;
    m_ok = 1'b1;
  endtask

  initial begin
    logic [11:0] a;
    int r;
    bus.req = 1'b0;
    bus.addr = '0;
    for (int i = 0; i < 3072; i++) mem[i] = $urandom;
    mem[0] = 32'h12345678;
    mem[5] = 32'hDEADBEEF;
    mem[3071] = 32'hA5A5_0F0F;

    #12;
    chk("rst_out",
        {24'd0, bus.ready, bus.valid, bus.err, arclk,
         drclk, arshft, drshft, ardin}, 32'h86);
    chk("rst_data", bus.data, 0);
    @(negedge clk);
    reset_n = 1'b1;

    rd(12'd5, 1'b0);
    rd(12'd6, 1'b0);
    rd(12'd3071, 1'b0);
    rd(12'd3072, 1'b0);
    rd(12'd5, 1'b1);
    rd(12'd9, 1'b0);
    rd(12'd5, 1'b0);
    rd(12'd3072, 1'b0);
    rd(12'd6, 1'b0);

    @(negedge clk);
    bus.req = 1'b1;
    bus.addr = 12'd0;
    @(posedge clk); #1;
    bus.req = 1'b0;
    repeat (300) @(posedge clk);
    #1;
    chk("mid_busy", 32'(bus.ready), 0);
    #1;
    reset_n = 1'b0;
    #1;
    chk("mid_rst",
        {24'd0, bus.ready, bus.valid, bus.err, arclk,
         drclk, arshft, drshft, ardin}, 32'h86);
    chk("mid_rst_data", bus.data, 0);
    @(negedge clk);
    reset_n = 1'b1;
    m_ok = 1'b0;

    rd(12'd0, 1'b0);
    rd(12'd1, 1'b0);

    for (int i = 0; i < 10; i++) begin
      r = $urandom_range(0, 9);
      if (r < 4 && m_ok) a = m_last + 12'd1;
      else if (r == 4) a = 12'(3072 + $urandom_range(0, 20));
      else a = 12'($urandom_range(0, 3071));
      rd(a, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
